// File: rtl/range_tracker_if.sv
// Sample/burst-control and result bundle for range_tracker.
// The master drives the burst controls and samples; the slave (the tracker) drives the results.
interface range_tracker_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               go;
  logic               finish;
  logic               data_valid;
  logic [WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]   min_out;
  logic [WIDTH-1:0]   max_out;
  logic [WIDTH-1:0]   range;
  logic [COUNT_W-1:0] sample_count;
  logic               done;
  logic               busy;
  logic               debug_error;

  modport master (
    output go, finish, data_valid, data_in,
    input  min_out, max_out, range, sample_count, done, busy, debug_error
  );

  modport slave (
    input  go, finish, data_valid, data_in,
    output min_out, max_out, range, sample_count, done, busy, debug_error
  );
endinterface

// File: rtl/range_tracker.sv
// Min/max/range tracker over a go/finish-bounded burst of qualified samples.
// Define RANGE_TRACKER_SIGNED_EN to treat samples as two's complement.
//
// state | meaning
// IDLE  | waiting for go; results from the last burst held
// RUN   | folding qualified samples into cur_min/cur_max/cnt
module range_tracker #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input logic         clock,
  input logic         reset,
  range_tracker_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cur_min_q, cur_min_d;
  logic [WIDTH-1:0]   cur_max_q, cur_max_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   min_out_q, min_out_d;
  logic [WIDTH-1:0]   max_out_q, max_out_d;
  logic [WIDTH-1:0]   range_q, range_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   fold_min, fold_max;
  logic [COUNT_W-1:0] fold_cnt;

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_TRACKER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Accumulators with the current sample folded in; an empty accumulator takes the sample as-is.
  always_comb begin
    fold_min = cur_min_q;
    fold_max = cur_max_q;
    if (cnt_q == '0) begin
      fold_min = bus.data_in;
      fold_max = bus.data_in;
    end else begin
      if (less_than(bus.data_in, cur_min_q)) fold_min = bus.data_in;
      if (less_than(cur_max_q, bus.data_in)) fold_max = bus.data_in;
    end
    fold_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d   = state_q;
    cur_min_d = cur_min_q;
    cur_max_d = cur_max_q;
    cnt_d     = cnt_q;
    min_out_d = min_out_q;
    max_out_d = max_out_q;
    range_d   = range_q;
    count_d   = count_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (bus.finish) begin
          err_d = 1'b1;
        end else if (bus.go) begin
          state_d = RUN;
          err_d   = 1'b0;
          if (bus.data_valid) begin
            cur_min_d = bus.data_in;
            cur_max_d = bus.data_in;
            cnt_d     = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
      end

      RUN: begin
        if (bus.data_valid) begin
          cur_min_d = fold_min;
          cur_max_d = fold_max;
          cnt_d     = fold_cnt;
        end
        if (bus.go) err_d = 1'b1;
        if (bus.finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (cnt_d == '0) begin
            min_out_d = '0;
            max_out_d = '0;
            range_d   = '0;
            count_d   = '0;
            err_d     = 1'b1;
          end else begin
            min_out_d = cur_min_d;
            max_out_d = cur_max_d;
            range_d   = cur_max_d - cur_min_d;
            count_d   = cnt_d;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cur_min_q <= '0;
      cur_max_q <= '0;
      cnt_q     <= '0;
      min_out_q <= '0;
      max_out_q <= '0;
      range_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_min_q <= cur_min_d;
      cur_max_q <= cur_max_d;
      cnt_q     <= cnt_d;
      min_out_q <= min_out_d;
      max_out_q <= max_out_d;
      range_q   <= range_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.min_out      = min_out_q;
  assign bus.max_out      = max_out_q;
  assign bus.range        = range_q;
  assign bus.sample_count = count_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.debug_error  = err_q;

endmodule
